data_mem_four_set_cache: RTL and testbench

- Word-addressed data memory for the single-cycle CPU, fronted by a 4-way set-associative cache.
- Holds a 512x32 backing store and a 16-set x 4-way, one-word-per-line cache.
- Read data is combinational.
- Writes are write-through, no-write-allocate.
- Read misses allocate into the cache on the next rising clock edge.

---
 rtl/data_mem_cache_pkg.sv | 29 ++
 rtl/cache_lru4.sv | 46 ++++
 rtl/data_mem_four_set_cache.sv | 149 ++++++++++++++
 tb/tb_data_mem_four_set_cache.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_cache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | data_mem_cache_pkg : address-field widths and line types for the cache |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package data_mem_cache_pkg;

  localparam int OFFSET  = 2;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 5;
  localparam int LINE_W  = 32;
  localparam int NWAYS   = 4;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [1:0]       age_t;
  typedef logic [1:0]       way_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru4.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cache_lru4 : 4-way age-based LRU update and victim selection per set   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module cache_lru4
  import data_mem_cache_pkg::*;
(
  input  age_t [NWAYS-1:0] ages_in,
  input  way_t             touch_way,
  input  logic [NWAYS-1:0] valid_mask,
  output age_t [NWAYS-1:0] ages_out,
  output way_t             victim_way
);

  age_t touched_age;
  logic found_invalid;

  assign touched_age = ages_in[touch_way];

  // Ways younger than the touched one age by one; older ways keep their age,
  // so the set stays a permutation of 0..NWAYS-1.
  for (genvar w = 0; w < NWAYS; w++) begin : g_way
    assign ages_out[w] = (way_t'(w) == touch_way)  ? age_t'(0) :
                         (ages_in[w] < touched_age) ? ages_in[w] + age_t'(1) :
                                                      ages_in[w];
  end

  always_comb begin
    victim_way    = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!found_invalid && !valid_mask[w]) begin
        victim_way    = way_t'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (ages_in[w] == age_t'(NWAYS - 1)) victim_way = way_t'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_four_set_cache.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | data_mem_four_set_cache : 512x32 data memory behind a 16x4 write-      |
// | through, no-write-allocate, read-allocate cache.   Rev 1.0             |
// +------------------------------------------------------------------------+
module data_mem_four_set_cache
  import data_mem_cache_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = LINE_W,
  parameter int SETS   = 16,
  parameter int WAYS   = NWAYS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  input  logic              RE,
  output logic [DATA_W-1:0] RD,
  output logic              Hit,
  output logic [15:0]       HitCnt,
  output logic [15:0]       MissCnt
);

  localparam int WORD_W = ADDR_W - OFFSET;
  localparam int DEPTH  = 1 << WORD_W;

  logic [DATA_W-1:0] mem_q  [DEPTH];
  tag_t              tag_q  [SETS][WAYS];
  logic [DATA_W-1:0] data_q [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  age_t [WAYS-1:0]   age_q [SETS];
  age_t [WAYS-1:0]   age_d [SETS];
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [WORD_W-1:0]  word;
  logic [INDEX_W-1:0] set_idx;
  tag_t               acc_tag;
  logic               access;
  logic               lookup_hit;
  line_t [WAYS-1:0]   set_lines;
  logic [WAYS-1:0]    way_hit;
  way_t               hit_way;
  way_t               victim_way;
  way_t               touch_way;
  age_t [WAYS-1:0]    ages_next;
  logic               mem_we;
  logic               cache_we;
  logic [DATA_W-1:0]  cache_wdata;
  logic               unused_byte_bits;

  assign word             = A[ADDR_W-1:OFFSET];
  assign set_idx          = A[OFFSET+INDEX_W-1:OFFSET];
  assign acc_tag          = A[ADDR_W-1:OFFSET+INDEX_W];
  assign unused_byte_bits = ^A[OFFSET-1:0];
  assign access           = RE | WE;

  for (genvar w = 0; w < WAYS; w++) begin : g_lookup
    assign set_lines[w] = '{valid: valid_q[set_idx][w],
                            tag:   tag_q[set_idx][w],
                            data:  data_q[set_idx][w]};
    assign way_hit[w]   = set_lines[w].valid && (set_lines[w].tag == acc_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = way_t'(w);
    end
  end

  assign lookup_hit = |way_hit;
  assign Hit        = access & lookup_hit;
  assign touch_way  = lookup_hit ? hit_way : victim_way;

  // The cache is always coherent with the store, so a miss can read through.
  always_comb begin
    RD = '0;
    if (RE) RD = lookup_hit ? set_lines[hit_way].data : mem_q[word];
  end

  cache_lru4 u_lru (
    .ages_in    (age_q[set_idx]),
    .touch_way  (touch_way),
    .valid_mask (valid_q[set_idx]),
    .ages_out   (ages_next),
    .victim_way (victim_way)
  );

  always_comb begin
    valid_d     = valid_q;
    age_d       = age_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_we      = 1'b0;
    cache_we    = 1'b0;
    cache_wdata = WE ? WD : mem_q[word];
    if (WE) begin
      mem_we = 1'b1;
      if (lookup_hit) begin
        cache_we       = 1'b1;
        age_d[set_idx] = ages_next;
      end
    end else if (RE) begin
      age_d[set_idx] = ages_next;
      if (!lookup_hit) begin
        cache_we                      = 1'b1;
        valid_d[set_idx][victim_way] = 1'b1;
      end
    end
    if (access) begin
      if (lookup_hit) hit_cnt_d  = sat_inc16(hit_cnt_q);
      else            miss_cnt_d = sat_inc16(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= age_t'(w);
      end
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      age_q      <= age_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Storage arrays carry no reset; only valid bits decide what is cached.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word] <= WD;
    if (cache_we) begin
      tag_q[set_idx][touch_way]  <= acc_tag;
      data_q[set_idx][touch_way] <= cache_wdata;
    end
  end

  assign HitCnt  = hit_cnt_q;
  assign MissCnt = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_four_set_cache.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_data_mem_four_set_cache : random and directed checks of the cached  |
// | data memory against a recency-list reference model.   Rev 1.0         |
// +------------------------------------------------------------------------+
module tb_data_mem_four_set_cache;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] A     = '0;
  logic [31:0] WD    = '0;
  logic        WE    = 1'b0;
  logic        RE    = 1'b0;
  logic [31:0] RD;
  logic        Hit;
  logic [15:0] HitCnt;
  logic [15:0] MissCnt;

  int total = 0;
  int bad   = 0;
  int word;
  int n_walk;

  always #10 clk = ~clk;

  data_mem_four_set_cache dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .WD      (WD),
    .WE      (WE),
    .RE      (RE),
    .RD      (RD),
    .Hit     (Hit),
    .HitCnt  (HitCnt),
    .MissCnt (MissCnt)
  );

  // Reference: flat memory plus, per set, which tags are resident and a
  // recency list (most recent first) of way numbers.
  bit [31:0] ref_mem  [512];
  bit        m_valid  [16][4];
  bit [4:0]  m_tag    [16][4];
  int        m_order  [16][4];
  int        m_hits;
  int        m_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t A=%h: got %h expected %h", name, $time, A, act, exp);
    end
  endtask

  function automatic int m_find(input logic [10:0] a);
    int s = int'(a[5:2]);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[10:6]) return w;
    return -1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < 4; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_order[s][w] = w;
      end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic void m_edge();
    int s = int'(A[5:2]);
    int w = m_find(A);
    if (RE || WE) begin
      if (w >= 0) m_hits   = (m_hits   < 65535) ? m_hits + 1   : m_hits;
      else        m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
    end
    if (WE) begin
      ref_mem[A[10:2]] = WD;
      if (w >= 0) m_touch(s, w);
    end else if (RE) begin
      if (w < 0) begin
        for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
        if (w < 0) w = m_order[s][3];
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = A[10:6];
      end
      m_touch(s, w);
    end
  endfunction

  task automatic drive(input logic [10:0] a, input logic re, input logic we, input logic [31:0] wd);
    A  = a;
    RE = re;
    WE = we;
    WD = wd;
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic sample();
    logic        exp_hit;
    logic [31:0] exp_rd;
    @(negedge clk);
    if (rst_n) begin
      exp_hit = (RE || WE) && (m_find(A) >= 0);
      exp_rd  = RE ? ref_mem[A[10:2]] : 32'h0;
      check("rd",      RD,      exp_rd);
      check("hit",     {31'h0, Hit} , {31'h0, exp_hit});
      check("hitcnt",  {16'h0, HitCnt},  32'(m_hits));
      check("misscnt", {16'h0, MissCnt}, 32'(m_misses));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
  endtask

  task automatic cycle(input logic [10:0] a, input logic re, input logic we, input logic [31:0] wd);
    drive(a, re, we, wd);
    sample();
    advance();
  endtask

  task automatic do_reset();
    RE    = 1'b0;
    WE    = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] set1 [5];
    set1[0] = 11'h004; set1[1] = 11'h044; set1[2] = 11'h084;
    set1[3] = 11'h0C4; set1[4] = 11'h104;

    #3;
    do_reset();
    for (int i = 0; i < 512; i++) cycle(11'(i * 4), 1'b0, 1'b1, 32'h0);
    do_reset();

    // Cold read, then warm read of the same word.
    drive(11'h000, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_rd_cold",  RD, 32'h0);
    check("lit_hit_cold", {31'h0, Hit}, 32'h0);
    advance();
    drive(11'h000, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_misscnt_1", {16'h0, MissCnt}, 32'd1);
    check("lit_hit_warm",  {31'h0, Hit}, 32'h1);
    advance();

    // Write miss does not allocate.
    drive(11'h040, 1'b0, 1'b1, 32'hDEADBEEF);
    sample();
    check("lit_hit_wr_miss", {31'h0, Hit}, 32'h0);
    advance();
    drive(11'h040, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_rd_after_wr",  RD, 32'hDEADBEEF);
    check("lit_hit_no_alloc", {31'h0, Hit}, 32'h0);
    advance();
    drive(11'h040, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_hit_after_fill", {31'h0, Hit}, 32'h1);
    advance();

    // Fill set 1 then evict the oldest line.
    for (int i = 0; i < 5; i++) cycle(set1[i], 1'b1, 1'b0, 32'h0);
    drive(11'h044, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_hit_044_kept", {31'h0, Hit}, 32'h1);
    advance();
    drive(11'h004, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_hit_004_evicted", {31'h0, Hit}, 32'h0);
    advance();

    // A touch between fills protects 0x004; 0x044 becomes the victim.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(set1[i], 1'b1, 1'b0, 32'h0);
    cycle(11'h004, 1'b1, 1'b0, 32'h0);
    cycle(11'h104, 1'b1, 1'b0, 32'h0);
    drive(11'h004, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_hit_004_protected", {31'h0, Hit}, 32'h1);
    advance();
    drive(11'h044, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_hit_044_victim", {31'h0, Hit}, 32'h0);
    advance();

    // Write-hit coherence.
    cycle(11'h1F0, 1'b1, 1'b0, 32'h0);
    drive(11'h1F0, 1'b0, 1'b1, 32'h12345678);
    sample();
    check("lit_hit_wr_hit", {31'h0, Hit}, 32'h1);
    advance();
    drive(11'h1F0, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_rd_wr_hit",  RD, 32'h12345678);
    check("lit_hit_rd_1f0", {31'h0, Hit}, 32'h1);
    advance();

    // Reset invalidates the cache but the backing store keeps the write.
    do_reset();
    drive(11'h1F0, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_rd_store_kept", RD, 32'h12345678);
    check("lit_hit_after_rst", {31'h0, Hit}, 32'h0);
    advance();

    // Simultaneous read and write: old data before the edge, new after.
    drive(11'h1F0, 1'b1, 1'b1, 32'h0ABCDEF0);
    sample();
    check("lit_rd_pre_write", RD, 32'h12345678);
    advance();
    drive(11'h1F0, 1'b1, 1'b0, 32'h0);
    sample();
    check("lit_rd_post_write", RD, 32'h0ABCDEF0);
    advance();

    // Random walk with occasional writes.
    do_reset();
    word   = 0;
    n_walk = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle(11'(word * 4), 1'b1, ($urandom_range(0, 3) == 0), $urandom);
      n_walk++;
      word += int'($urandom_range(1, 5));
      if (word > 500) word = int'($urandom_range(0, 399));
    end
    drive(11'h000, 1'b0, 1'b0, 32'h0);
    sample();
    check("lit_cnt_sum", 32'(HitCnt) + 32'(MissCnt), 32'(n_walk));
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
